// File: rtl/mc_control_pkg.sv
// lc3b_types: shared LC-3b encodings for the multicycle control unit and
// its datapath-facing interface.
//   lc3b_opcode       - IR[15:12] instruction opcodes
//   lc3b_aluop        - ALU function select
//   lc3b_mem_wmask    - per-byte write/read lane mask
//   pcmux_sel_t       - PC source select
//   regfilemux_sel_t  - register-file write-data select
//   alumux_sel_t      - ALU B-operand select
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3,
        alu_sll  = 3'd4,
        alu_srl  = 3'd5,
        alu_sra  = 3'd6
    } lc3b_aluop;

    typedef logic [1:0] lc3b_mem_wmask;

    localparam lc3b_mem_wmask WMASK_WORD = 2'b11;
    localparam lc3b_mem_wmask WMASK_LO   = 2'b01;
    localparam lc3b_mem_wmask WMASK_HI   = 2'b10;

    typedef enum logic [1:0] {
        pcmux_plus2 = 2'd0,
        pcmux_off9  = 2'd1,
        pcmux_base  = 2'd2,
        pcmux_off11 = 2'd3
    } pcmux_sel_t;

    typedef enum logic [1:0] {
        rfmux_alu      = 2'd0,
        rfmux_mdr      = 2'd1,
        rfmux_pc       = 2'd2,
        rfmux_mdr_byte = 2'd3
    } regfilemux_sel_t;

    typedef enum logic [1:0] {
        alumux_sr2      = 2'd0,
        alumux_off6     = 2'd1,
        alumux_imm5     = 2'd2,
        alumux_off6_raw = 2'd3
    } alumux_sel_t;

    // Byte-wide memory instructions use the unscaled offset and byte lanes.
    function automatic logic is_byte_op(lc3b_opcode op);
        return (op == op_ldb) || (op == op_stb);
    endfunction

    function automatic logic is_load_op(lc3b_opcode op);
        return (op == op_ldr) || (op == op_ldb);
    endfunction

endpackage

// File: rtl/mc_control_if.sv
// mc_control_if: bundle between the control FSM and the LC-3b datapath.
//   Datapath -> control: opcode, IR decode bits, mar_lsb, branch_enable,
//                        mem_resp.
//   Control -> datapath: register load enables, mux selects, aluop,
//                        memory strobes/byte lanes, mem_err.
// Modports: master = control unit, slave = datapath/memory side.
interface mc_control_if;
    import lc3b_types::*;

    lc3b_opcode      opcode;
    logic            ir_bit11;
    logic            ir_bit5;
    logic            ir_bit4;
    logic            ir_bit5_shf;
    logic            mar_lsb;
    logic            branch_enable;
    logic            mem_resp;

    logic            load_pc;
    logic            load_ir;
    logic            load_mar;
    logic            load_mdr;
    logic            load_regfile;
    logic            load_cc;
    pcmux_sel_t      pcmux_sel;
    logic            marmux_sel;
    logic            mdrmux_sel;
    regfilemux_sel_t regfilemux_sel;
    alumux_sel_t     alumux_sel;
    logic            storemux_sel;
    logic            destmux_sel;
    lc3b_aluop       aluop;
    logic            mem_read;
    logic            mem_write;
    lc3b_mem_wmask   mem_byte_enable;
    logic            mem_err;

    modport master (
        input  opcode, ir_bit11, ir_bit5, ir_bit4, ir_bit5_shf, mar_lsb,
               branch_enable, mem_resp,
        output load_pc, load_ir, load_mar, load_mdr, load_regfile, load_cc,
               pcmux_sel, marmux_sel, mdrmux_sel, regfilemux_sel, alumux_sel,
               storemux_sel, destmux_sel, aluop, mem_read, mem_write,
               mem_byte_enable, mem_err
    );

    modport slave (
        output opcode, ir_bit11, ir_bit5, ir_bit4, ir_bit5_shf, mar_lsb,
               branch_enable, mem_resp,
        input  load_pc, load_ir, load_mar, load_mdr, load_regfile, load_cc,
               pcmux_sel, marmux_sel, mdrmux_sel, regfilemux_sel, alumux_sel,
               storemux_sel, destmux_sel, aluop, mem_read, mem_write,
               mem_byte_enable, mem_err
    );

endinterface

// File: rtl/mc_mem_timer.sv
// mc_mem_timer: counts consecutive memory wait cycles and flags an abort
// when MEM_TIMEOUT cycles pass without mem_resp.
//   clk, srst-style rst : clock and synchronous active-high reset
//   waiting             : FSM is in a memory wait state this cycle
//   mem_resp            : memory done pulse
//   timeout             : abort this cycle (combinational, one cycle wide)
// MEM_TIMEOUT = 0 disables the abort entirely.
module mc_mem_timer #(
    parameter int MEM_TIMEOUT = 0,
    parameter int TO_W        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic mem_resp,
    output logic timeout
);

    // The abort fires while the counter shows MEM_TIMEOUT-1, i.e. on the
    // MEM_TIMEOUT-th wait cycle, since the first wait cycle sees zero.
    localparam logic [TO_W-1:0] LIMIT =
        TO_W'((MEM_TIMEOUT == 0) ? 0 : (MEM_TIMEOUT - 1));

    logic [TO_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || !waiting || mem_resp || timeout) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + TO_W'(1);
        end
    end

    assign timeout = (MEM_TIMEOUT != 0) && waiting && !mem_resp &&
                     (count_reg == LIMIT);

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle LC-3b control FSM (second generation).
// Decodes opcode/IR bits presented by the datapath and drives load enables,
// mux selects, ALU op and memory strobes. Outputs depend on the current
// state plus the stable IR/MAR bits of the instruction in flight.
//   clk, rst : clock, synchronous active-high reset (state -> FETCH1)
//   bus      : mc_control_if.master (datapath decode inputs, mem_resp,
//              all control outputs, mem_err abort pulse)
// Optional feature macro MC_CONTROL_PERF_EN adds:
//   retired [PERF_W] : instructions completed (entries to FETCH1 from a
//                      non-fetch state, timeouts excluded)
//   stall   [PERF_W] : wait-state cycles with mem_resp low
module mc_control #(
    parameter int MEM_TIMEOUT = 0,
    parameter int TO_W        = 8,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    mc_control_if.master      bus
`ifdef MC_CONTROL_PERF_EN
    ,
    output logic [PERF_W-1:0] retired,
    output logic [PERF_W-1:0] stall
`endif
);
    import lc3b_types::*;

    typedef enum logic [4:0] {
        FETCH1, FETCH2, FETCH3, DECODE,
        S_ADD, S_AND, S_NOT, S_BR, BR_TAKEN, S_JMP,
        JSR1, JSR2, S_LEA, S_SHF,
        CALC_ADDR, LD1, LD2, ST1, ST2
    } state_t;

    state_t state_reg, state_next;

    logic            waiting;
    logic            timeout;

    logic            load_pc, load_ir, load_mar, load_mdr, load_regfile, load_cc;
    pcmux_sel_t      pcmux_sel;
    logic            marmux_sel, mdrmux_sel;
    regfilemux_sel_t regfilemux_sel;
    alumux_sel_t     alumux_sel;
    logic            storemux_sel, destmux_sel;
    lc3b_aluop       aluop;
    logic            mem_read, mem_write;
    lc3b_mem_wmask   mem_byte_enable;
    logic            mem_err;

    assign waiting = (state_reg == FETCH2) || (state_reg == LD1) ||
                     (state_reg == ST2);

    mc_mem_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .waiting  (waiting),
        .mem_resp (bus.mem_resp),
        .timeout  (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FETCH1;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_regfile    = 1'b0;
        load_cc         = 1'b0;
        pcmux_sel       = pcmux_plus2;
        marmux_sel      = 1'b0;
        mdrmux_sel      = 1'b0;
        regfilemux_sel  = rfmux_alu;
        alumux_sel      = alumux_sr2;
        storemux_sel    = 1'b0;
        destmux_sel     = 1'b0;
        aluop           = alu_add;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = WMASK_WORD;
        mem_err         = timeout;

        unique case (state_reg)
            FETCH1: begin
                marmux_sel = 1'b1;
                load_mar   = 1'b1;
                load_pc    = 1'b1;
                state_next = FETCH2;
            end
            FETCH2: begin
                mem_read   = 1'b1;
                mdrmux_sel = 1'b1;
                load_mdr   = 1'b1;
                if (timeout) begin
                    state_next = FETCH1;
                end else if (bus.mem_resp) begin
                    state_next = FETCH3;
                end
            end
            FETCH3: begin
                load_ir    = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                case (bus.opcode)
                    op_add:                        state_next = S_ADD;
                    op_and:                        state_next = S_AND;
                    op_not:                        state_next = S_NOT;
                    op_br:                         state_next = S_BR;
                    op_jmp:                        state_next = S_JMP;
                    op_jsr:                        state_next = JSR1;
                    op_lea:                        state_next = S_LEA;
                    op_shf:                        state_next = S_SHF;
                    op_ldr, op_ldb, op_str, op_stb: state_next = CALC_ADDR;
                    // RTI, TRAP, LDI, STI execute as no-ops.
                    default:                       state_next = FETCH1;
                endcase
            end
            S_ADD, S_AND: begin
                alumux_sel   = bus.ir_bit5 ? alumux_imm5 : alumux_sr2;
                aluop        = (state_reg == S_AND) ? alu_and : alu_add;
                load_regfile = 1'b1;
                load_cc      = 1'b1;
                state_next   = FETCH1;
            end
            S_NOT: begin
                aluop        = alu_not;
                load_regfile = 1'b1;
                load_cc      = 1'b1;
                state_next   = FETCH1;
            end
            S_BR: begin
                state_next = bus.branch_enable ? BR_TAKEN : FETCH1;
            end
            BR_TAKEN: begin
                pcmux_sel  = pcmux_off9;
                load_pc    = 1'b1;
                state_next = FETCH1;
            end
            S_JMP: begin
                pcmux_sel  = pcmux_base;
                load_pc    = 1'b1;
                state_next = FETCH1;
            end
            JSR1: begin
                // R7 <= PC; the datapath latches the JSRR base this cycle so
                // JSRR R7 still jumps to the old R7.
                destmux_sel    = 1'b1;
                regfilemux_sel = rfmux_pc;
                load_regfile   = 1'b1;
                state_next     = JSR2;
            end
            JSR2: begin
                pcmux_sel  = bus.ir_bit11 ? pcmux_off11 : pcmux_base;
                load_pc    = 1'b1;
                state_next = FETCH1;
            end
            S_LEA: begin
                regfilemux_sel = rfmux_pc;
                load_regfile   = 1'b1;
                load_cc        = 1'b1;
                state_next     = FETCH1;
            end
            S_SHF: begin
                if (!bus.ir_bit4) begin
                    aluop = alu_sll;
                end else if (bus.ir_bit5_shf) begin
                    aluop = alu_sra;
                end else begin
                    aluop = alu_srl;
                end
                load_regfile = 1'b1;
                load_cc      = 1'b1;
                state_next   = FETCH1;
            end
            CALC_ADDR: begin
                alumux_sel = is_byte_op(bus.opcode) ? alumux_off6_raw : alumux_off6;
                load_mar   = 1'b1;
                state_next = is_load_op(bus.opcode) ? LD1 : ST1;
            end
            LD1: begin
                mem_read   = 1'b1;
                mdrmux_sel = 1'b1;
                load_mdr   = 1'b1;
                if (timeout) begin
                    state_next = FETCH1;
                end else if (bus.mem_resp) begin
                    state_next = LD2;
                end
            end
            LD2: begin
                regfilemux_sel = (bus.opcode == op_ldb) ? rfmux_mdr_byte : rfmux_mdr;
                load_regfile   = 1'b1;
                load_cc        = 1'b1;
                state_next     = FETCH1;
            end
            ST1: begin
                storemux_sel = 1'b1;
                aluop        = alu_pass;
                load_mdr     = 1'b1;
                state_next   = ST2;
            end
            ST2: begin
                mem_write = 1'b1;
                if (bus.opcode == op_stb) begin
                    mem_byte_enable = bus.mar_lsb ? WMASK_HI : WMASK_LO;
                end
                if (timeout || bus.mem_resp) begin
                    state_next = FETCH1;
                end
            end
            default: begin
                state_next = FETCH1;
            end
        endcase
    end

    assign bus.load_pc         = load_pc;
    assign bus.load_ir         = load_ir;
    assign bus.load_mar        = load_mar;
    assign bus.load_mdr        = load_mdr;
    assign bus.load_regfile    = load_regfile;
    assign bus.load_cc         = load_cc;
    assign bus.pcmux_sel       = pcmux_sel;
    assign bus.marmux_sel      = marmux_sel;
    assign bus.mdrmux_sel      = mdrmux_sel;
    assign bus.regfilemux_sel  = regfilemux_sel;
    assign bus.alumux_sel      = alumux_sel;
    assign bus.storemux_sel    = storemux_sel;
    assign bus.destmux_sel     = destmux_sel;
    assign bus.aluop           = aluop;
    assign bus.mem_read        = mem_read;
    assign bus.mem_write       = mem_write;
    assign bus.mem_byte_enable = mem_byte_enable;
    assign bus.mem_err         = mem_err;

`ifdef MC_CONTROL_PERF_EN
    logic [PERF_W-1:0] retired_reg, stall_reg;
    logic              in_fetch;

    assign in_fetch = (state_reg == FETCH1) || (state_reg == FETCH2) ||
                      (state_reg == FETCH3);

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_reg <= '0;
            stall_reg   <= '0;
        end else begin
            if ((state_next == FETCH1) && !in_fetch && !timeout) begin
                retired_reg <= retired_reg + PERF_W'(1);
            end
            if (waiting && !bus.mem_resp) begin
                stall_reg <= stall_reg + PERF_W'(1);
            end
        end
    end

    assign retired = retired_reg;
    assign stall   = stall_reg;
`endif

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized scoreboard bench for mc_control (MEM_TIMEOUT=4).
// The stimulus expands each instruction into the cycle-by-cycle control
// actions the LC-3b microsequence requires and queues them; an independent
// monitor compares the DUT outputs every cycle against the queue head.
module tb_mc_control;
    import lc3b_types::*;

    localparam int MEM_TO = 4;

    typedef struct packed {
        logic       load_pc, load_ir, load_mar, load_mdr, load_regfile, load_cc;
        logic [1:0] pcmux;
        logic       marmux, mdrmux;
        logic [1:0] rfmux, alumux;
        logic       storemux, destmux;
        logic [2:0] aluop;
        logic       mem_read, mem_write;
        logic [1:0] mbe;
        logic       mem_err;
    } outs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_control_if bus();
`ifdef MC_CONTROL_PERF_EN
    logic [31:0] retired, stall;
`endif

    mc_control #(
        .MEM_TIMEOUT (MEM_TO),
        .TO_W        (8),
        .PERF_W      (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MC_CONTROL_PERF_EN
        ,
        .retired (retired),
        .stall   (stall)
`endif
    );

    outs_t exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    int    m_retired = 0;
    int    m_stall = 0;

    // Instruction fields applied together with the first cycle of an instr.
    logic [3:0] p_op;
    bit p_b11, p_b5, p_b4, p_b5s, p_lsb, p_ben, p_load = 0;

    function automatic outs_t dflt();
        outs_t o;
        o = '0;
        o.aluop = alu_add;
        o.mbe = 2'b11;
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.load_pc = bus.load_pc;        o.load_ir = bus.load_ir;
        o.load_mar = bus.load_mar;      o.load_mdr = bus.load_mdr;
        o.load_regfile = bus.load_regfile; o.load_cc = bus.load_cc;
        o.pcmux = bus.pcmux_sel;        o.marmux = bus.marmux_sel;
        o.mdrmux = bus.mdrmux_sel;      o.rfmux = bus.regfilemux_sel;
        o.alumux = bus.alumux_sel;      o.storemux = bus.storemux_sel;
        o.destmux = bus.destmux_sel;    o.aluop = bus.aluop;
        o.mem_read = bus.mem_read;      o.mem_write = bus.mem_write;
        o.mbe = bus.mem_byte_enable;    o.mem_err = bus.mem_err;
        return o;
    endfunction

    // Monitor: one comparison per cycle whenever an expectation is queued.
    outs_t mon_e, mon_a;
    string mon_t;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_t = tag_q.pop_front();
                mon_a = sample();
                checks++;
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL %s: dut=%h expected=%h", mon_t, mon_a, mon_e);
                end
            end
        end
    end

    task automatic cyc(input outs_t e, input bit resp, input string t, input bit r);
        @(negedge clk);
        rst = r;
        bus.mem_resp = resp;
        if (p_load) begin
            bus.opcode = lc3b_opcode'(p_op);
            bus.ir_bit11 = p_b11; bus.ir_bit5 = p_b5; bus.ir_bit4 = p_b4;
            bus.ir_bit5_shf = p_b5s; bus.mar_lsb = p_lsb; bus.branch_enable = p_ben;
            p_load = 0;
        end
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    // Non-wait cycle: a stray mem_resp must be ignored, so inject some.
    task automatic cyc_n(input outs_t e, input string t);
        cyc(e, ($urandom_range(0, 3) == 0), t, 1'b0);
    endtask

    // Memory access lasting d idle cycles before mem_resp; d >= MEM_TO aborts.
    task automatic access(input outs_t e, input int d, input string t, output bit aborted);
        outs_t x;
        aborted = (d >= MEM_TO);
        if (aborted) begin
            for (int i = 0; i < MEM_TO; i++) begin
                x = e;
                if (i == MEM_TO - 1) x.mem_err = 1'b1;
                cyc(x, 1'b0, t, 1'b0);
                m_stall++;
            end
        end else begin
            for (int i = 0; i < d; i++) begin
                cyc(e, 1'b0, t, 1'b0);
                m_stall++;
            end
            cyc(e, 1'b1, t, 1'b0);
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input bit b11, b5, b4, b5s, lsb, ben,
                             input int df, dm, rst_at);
        outs_t e;
        bit ab;
        p_op = op; p_b11 = b11; p_b5 = b5; p_b4 = b4; p_b5s = b5s;
        p_lsb = lsb; p_ben = ben; p_load = 1;
        $display("instr op=%h b11=%0d b5=%0d b4=%0d shf=%0d lsb=%0d ben=%0d fwait=%0d mwait=%0d rst_at=%0d",
                 op, b11, b5, b4, b5s, lsb, ben, df, dm, rst_at);
        e = dflt(); e.load_pc = 1; e.load_mar = 1; e.marmux = 1;
        cyc_n(e, "FETCH1");
        e = dflt(); e.mem_read = 1; e.mdrmux = 1; e.load_mdr = 1;
        access(e, df, "FETCH2", ab);
        if (ab) return;
        e = dflt(); e.load_ir = 1;
        cyc_n(e, "FETCH3");
        cyc_n(dflt(), "DECODE");
        e = dflt();
        case (op)
            4'b0001, 4'b0101: begin
                e.alumux = b5 ? 2'd2 : 2'd0;
                if (op == 4'b0101) e.aluop = alu_and;
                e.load_regfile = 1; e.load_cc = 1;
                cyc_n(e, "ADD_AND");
            end
            4'b1001: begin
                e.aluop = alu_not; e.load_regfile = 1; e.load_cc = 1;
                cyc_n(e, "NOT");
            end
            4'b0000: begin
                cyc_n(e, "BR");
                if (ben) begin
                    e.pcmux = 2'd1; e.load_pc = 1;
                    cyc_n(e, "BR_TAKEN");
                end
            end
            4'b1100: begin
                e.pcmux = 2'd2; e.load_pc = 1;
                cyc_n(e, "JMP");
            end
            4'b0100: begin
                e.destmux = 1; e.rfmux = 2'd2; e.load_regfile = 1;
                cyc_n(e, "JSR1");
                e = dflt(); e.pcmux = b11 ? 2'd3 : 2'd2; e.load_pc = 1;
                cyc_n(e, "JSR2");
            end
            4'b1110: begin
                e.rfmux = 2'd2; e.load_regfile = 1; e.load_cc = 1;
                cyc_n(e, "LEA");
            end
            4'b1101: begin
                e.aluop = !b4 ? alu_sll : (b5s ? alu_sra : alu_srl);
                e.load_regfile = 1; e.load_cc = 1;
                cyc_n(e, "SHF");
            end
            4'b0110, 4'b0010: begin
                e.alumux = (op == 4'b0010) ? 2'd3 : 2'd1; e.load_mar = 1;
                cyc_n(e, "CALC_ADDR");
                e = dflt(); e.mem_read = 1; e.mdrmux = 1; e.load_mdr = 1;
                access(e, dm, "LD1", ab);
                if (ab) return;
                e = dflt(); e.rfmux = (op == 4'b0010) ? 2'd3 : 2'd1;
                e.load_regfile = 1; e.load_cc = 1;
                cyc_n(e, "LD2");
            end
            4'b0111, 4'b0011: begin
                e.alumux = (op == 4'b0011) ? 2'd3 : 2'd1; e.load_mar = 1;
                cyc_n(e, "CALC_ADDR");
                e = dflt(); e.storemux = 1; e.aluop = alu_pass; e.load_mdr = 1;
                cyc_n(e, "ST1");
                e = dflt(); e.mem_write = 1;
                if (op == 4'b0011) e.mbe = lsb ? 2'b10 : 2'b01;
                if (rst_at >= 0) begin
                    for (int i = 0; i < rst_at; i++) cyc(e, 1'b0, "ST2", 1'b0);
                    cyc(e, 1'b0, "ST2_rst", 1'b1);
                    m_retired = 0;
                    m_stall = 0;
                    return;
                end
                access(e, dm, "ST2", ab);
                if (ab) return;
            end
            default: ;
        endcase
        m_retired++;
    endtask

    function automatic int rand_wait();
        int r;
        r = $urandom_range(0, 15);
        return (r < 14) ? (r % 4) : (MEM_TO + r % 2);
    endfunction

    initial begin
        outs_t e;
        bus.opcode = op_br; bus.ir_bit11 = 0; bus.ir_bit5 = 0; bus.ir_bit4 = 0;
        bus.ir_bit5_shf = 0; bus.mar_lsb = 0; bus.branch_enable = 0; bus.mem_resp = 0;
        @(negedge clk);
        e = dflt(); e.load_pc = 1; e.load_mar = 1; e.marmux = 1;
        cyc(e, 1'b0, "reset_FETCH1", 1'b1);

        // Directed cases.
        run_instr(4'b0001, 0, 1, 0, 0, 0, 0, 3, 0, -1);        // fetch wait 3, ADD imm5
        run_instr(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, -1);        // BR not taken
        run_instr(4'b0000, 0, 0, 0, 0, 0, 1, 1, 0, -1);        // BR taken
        run_instr(4'b0011, 0, 0, 0, 0, 1, 0, 0, 2, -1);        // STB high lane
        run_instr(4'b0100, 1, 0, 0, 0, 0, 0, 0, 0, -1);        // JSR offset
        run_instr(4'b0110, 0, 0, 0, 0, 0, 0, 0, MEM_TO, -1);   // LDR timeout
        run_instr(4'b0111, 0, 0, 0, 0, 0, 0, 1, 3, 1);         // reset mid-ST2
        run_instr(4'b0101, 0, 0, 0, 0, 0, 0, MEM_TO, 0, -1);   // fetch timeout
        run_instr(4'b0010, 0, 0, 0, 0, 1, 0, 2, 3, -1);        // LDB, wait 3 boundary

        for (int n = 0; n < 300; n++) begin
            logic [3:0] op;
            int ra;
            op = 4'($urandom_range(0, 15));
            ra = (($urandom_range(0, 39) == 0) ? int'($urandom_range(0, MEM_TO - 2)) : -1);
            run_instr(op, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), rand_wait(), rand_wait(), ra);
        end

        repeat (3) @(negedge clk);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: dut_left=%0d expected=0", exp_q.size());
        end
`ifdef MC_CONTROL_PERF_EN
        checks++;
        if (retired !== 32'(m_retired)) begin
            errors++;
            $display("FAIL retired: dut=%0d expected=%0d", retired, m_retired);
        end
        checks++;
        if (stall !== 32'(m_stall)) begin
            errors++;
            $display("FAIL stall: dut=%0d expected=%0d", stall, m_stall);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
